// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: key codes, event FSM states,
// and the arrow-key classifier used to enable auto-repeat.
package kbd_pkg;

  localparam logic [7:0] KEY_UP    = 8'd1;
  localparam logic [7:0] KEY_DOWN  = 8'd2;
  localparam logic [7:0] KEY_LEFT  = 8'd3;
  localparam logic [7:0] KEY_RIGHT = 8'd4;
  localparam logic [7:0] KEY_ENTER = 8'd13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    DELAY  = 2'd2,
    REPEAT = 2'd3
  } kstate_t;

  function automatic logic is_arrow(
    input logic [7:0] code
  );
    return (code >= KEY_UP) &&
           (code <= KEY_RIGHT);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Sync first-word-fall-through FIFO for key events.
// Ports: i_push/i_data in, i_pop out; o_valid/o_head/o_count/o_full status.
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [W-1:0]                   i_data,
  input  logic                           i_pop,
  output logic                           o_valid,
  output logic [W-1:0]                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_valid ? r_mem[r_rptr] : '0;

  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_pop  = i_pop & o_valid;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns held-key levels into press events with arrow auto-repeat, queued in a FWFT FIFO.
// Ports: clk_in/rst, key_state/key_ascii in, evt_* handshake out, overflow flag.
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       key_state,
  input  logic [7:0]                 key_ascii,
  input  logic                       evt_ready,
  input  logic                       ovf_clr,
  output logic                       evt_valid,
  output logic [7:0]                 evt_code,
  output logic [$clog2(DEPTH+1)-1:0] evt_count,
  output logic                       overflow
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_DLY = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_PER = TW'(REPEAT_PERIOD - 1);

  kstate_t       r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_held;
  logic          r_state_in;
  logic [7:0]    r_ascii_in;
  logic          r_ovf;

  logic          w_press;
  logic          w_release;
  logic          w_tick;
  logic          w_rpt;
  logic          w_push;
  logic [7:0]    w_data;
  logic          w_full;
  logic          w_drop;
  kstate_t       w_target;

  assign w_press = key_state && (key_ascii != 8'd0) &&
                   (!r_state_in || key_ascii != r_ascii_in);
  assign w_release = !key_state || (key_ascii == 8'd0);

  assign w_target = (REPEAT_EN && is_arrow(key_ascii)) ?
                    DELAY : HOLD;

  assign w_rpt  = (r_state == DELAY) || (r_state == REPEAT);
  assign w_tick = ((r_state == DELAY)  && (r_timer == T_DLY)) ||
                  ((r_state == REPEAT) && (r_timer == T_PER));

  // A fresh press always wins over a repeat tick in the same cycle.
  assign w_push = w_press | (w_tick & ~w_release);
  assign w_data = w_press ? key_ascii : r_held;
  assign w_drop = w_push & w_full & ~(evt_valid & evt_ready);

  assign overflow = r_ovf;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_held     <= '0;
      r_state_in <= 1'b0;
      r_ascii_in <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state_in <= key_state;
      r_ascii_in <= key_ascii;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      if (w_press) begin
        r_held  <= key_ascii;
        r_timer <= '0;
        r_state <= w_target;
      end else if (w_release) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else if (w_rpt) begin
        if (w_tick) begin
          r_state <= REPEAT;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_data  (w_data),
    .i_pop   (evt_ready),
    .o_valid (evt_valid),
    .o_head  (evt_code),
    .o_count (evt_count),
    .o_full  (w_full)
  );

endmodule

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Sits directly downstream of the PS/2 keyboard decoder, consuming its `key_state` and `key_ascii` outputs.
- Turns the level-style "key held / code" view into discrete key-press events, with auto-repeat for arrow keys.
- Buffers events in a small first-word-fall-through (FWFT) FIFO.
- Game and menu logic pops events through a valid/ready handshake, so no key press is lost while the consumer is busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- REPEAT_EN, 1, 1 = arrow-key auto-repeat enabled; 0 = one event per press.
- REPEAT_DELAY, 50000000, cycles from press to first repeat (500 ms at 100 MHz).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeats (100 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- key_state  input  1  1 while a key is held (from the keyboard decoder)
- key_ascii  input  8  code of the held key; 0 = unmapped
- evt_ready  input  1  consumer accepts the head event this cycle
- ovf_clr  input  1  clears the overflow flag
- evt_valid  output  1  FIFO non-empty
- evt_code  output  8  head event code; 0 when empty
- evt_count  output  $clog2(DEPTH+1)  number of queued events
- overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, timer 0, input history registers 0.
- Input history: `state_r` and `ascii_r` register `key_state` and `key_ascii` every cycle.
- press = `key_state` & (`key_ascii` != 0) & (!`state_r` | `key_ascii` != `ascii_r`).
  - A second key pressed while the first is still held counts as a new press.
- release = !`key_state` | (`key_ascii` == 0).
- FSM states:
  - IDLE: press -> push `key_ascii`. Go to DELAY if REPEAT_EN and code is 1..4, else go to HOLD. Timer <= 0.
  - HOLD: release -> IDLE. press -> push, then re-evaluate the target state as in IDLE.
  - DELAY: timer increments. At timer == REPEAT_DELAY-1, push the held code, timer <= 0, go to REPEAT.
  - REPEAT: timer increments. At timer == REPEAT_PERIOD-1, push the held code, timer <= 0.
  - DELAY and REPEAT: release -> IDLE with no push. press -> push the new code and restart as from IDLE.
- Held code: a register loaded on every press. Repeats push this register, not the live input.
- Push priority: at most one push per cycle. A press in the same cycle as a repeat tick produces only the press push.
- Latency: press at cycle N gives `evt_valid` = 1 at N+1 if the FIFO was empty. `evt_code` is driven from the head register, not combinationally from the input.
- FIFO:
  - Pop when `evt_valid` & `evt_ready`. `evt_ready` with the FIFO empty is ignored.
  - Push and pop in the same cycle: allowed at any occupancy, including full; `evt_count` unchanged.
  - Push when full with no pop: event dropped, `overflow` <= 1, `evt_count` stays DEPTH.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- overflow: held until `ovf_clr`. Clear wins over a simultaneous new overflow? No — set wins: a same-cycle drop and `ovf_clr` leaves `overflow` = 1.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); it saturates only via the compare and never wraps.
- Reset mid-hold: on rst release, `state_r` = 0, so a still-held key produces one fresh press event. This is intended.

Decomposition:
- Shared package `kbd_pkg` holds:
  - key-code constants KEY_UP = 8'd1, KEY_DOWN = 8'd2, KEY_LEFT = 8'd3, KEY_RIGHT = 8'd4, KEY_ENTER = 8'd13;
  - the FSM state encoding (IDLE, HOLD, DELAY, REPEAT, 2 bits);
  - an is_arrow(code) function.
- Sub-module `key_fifo`: parameterised sync FWFT FIFO (push, data, pop, valid, head, count, full). It is instantiated once; the FSM, edge detection and overflow flag stay in the top module.

Test Plan (DEPTH=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Press 'Z' (`key_state`=1, `key_ascii`=8'h5A) for 100 cycles, `evt_ready`=1 -> exactly one event 8'h5A; `evt_valid` high 1 cycle after the press; no repeats.
- Hold UP (8'd1) 40 cycles, `evt_ready`=1 -> events at press, +20, +25, +30, +35 (5 total); none after release.
- Hold 'X', then switch `key_ascii` to 'C' with `key_state` still 1 -> two events, 8'h58 then 8'h43.
- `evt_ready`=0, six distinct presses -> `evt_count`=4, `overflow`=1, queue holds the first four codes in order; `ovf_clr` pulse -> `overflow`=0.
- Full FIFO, press coincides with `evt_ready`=1 -> `evt_count` stays 4, head advances, new code at the tail, `overflow` stays 0.
- Assert rst during REPEAT with 3 queued -> `evt_valid`=0, `evt_count`=0 immediately; after rst release with the key still held -> one new event.
